ring_phase_monitor: RTL and testbench

//  Downstream checker for the 4-bit one-hot ring counter output. Samples phase vector every
//  clk, verifies legal one-hot rotate-left sequence 0001->0010->0100->1000->0001, locks after

---
 rtl/ring_phase_monitor_if.sv | 29 ++
 rtl/ring_phase_monitor.sv | 153 +++++++++++++++
 tb/tb_ring_phase_monitor.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/ring_phase_monitor_if.sv
// Bundles the phase vector, the clear strobe and the monitor status outputs.
// The master side drives phase_in and clear and observes the status.
// The slave side is the monitor itself.
interface ring_phase_monitor_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] phase_in;
    logic             clear;
    logic [1:0]       state;
    logic             locked;
    logic             fault;
    logic [IDX_W-1:0] phase_idx;
    logic             phase_vld;
    logic [CNT_W-1:0] rev_count;
    logic [CNT_W-1:0] err_count;

    modport master (
        output phase_in, clear,
        input  state, locked, fault, phase_idx, phase_vld, rev_count, err_count
    );

    modport slave (
        input  phase_in, clear,
        output state, locked, fault, phase_idx, phase_vld, rev_count, err_count
    );
endinterface

// File: rtl/ring_phase_monitor.sv
// ring_phase_monitor: checks that a one-hot ring counter rotates left one bit per
// clock, locks after clean revolutions, counts revolutions and sequence errors.
// Optional feature macro: RING_MON_ERRCNT_EN (saturating err_count; tied to 0 otherwise).
//
// state  | meaning
// IDLE   | waiting for the first 0001 sample after reset
// TRACK  | following the sequence, counting clean revolutions toward lock
// LOCKED | LOCK_REVS clean revolutions seen, still checking every sample
// FAULT  | sequence broken; waits for a 0001 sample to resynchronise
module ring_phase_monitor #(
    parameter int WIDTH     = 4,
    parameter int CNT_W     = 8,
    parameter int LOCK_REVS = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    ring_phase_monitor_if.slave    bus
);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GR_W  = $clog2(LOCK_REVS + 1);

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] TRACK  = 2'b01;
    localparam logic [1:0] LOCKED = 2'b10;
    localparam logic [1:0] FAULT  = 2'b11;

    logic [1:0]       state_q, state_nxt;
    logic [GR_W-1:0]  good_q, good_nxt;
    logic [WIDTH-1:0] prev_q;
    logic [IDX_W-1:0] idx_q, idx_comb;
    logic             vld_q;
    logic             locked_q;
    logic             fault_q;
    logic [CNT_W-1:0] rev_q;
    logic             onehot, wrap, match;
    logic             rev_inc, err_evt;
    logic [WIDTH-1:0] expected;

    assign onehot   = $onehot(bus.phase_in);
    assign wrap     = onehot && bus.phase_in[0];
    assign expected = {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};
    // prev is always one-hot while checking, so all-zero, multi-hot and stalled
    // samples all fall out as mismatches here.
    assign match    = (bus.phase_in == expected);

    // Binary index of the set bit; only used when the sample is one-hot.
    always_comb begin
        idx_comb = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (bus.phase_in[i]) idx_comb = IDX_W'(i);
        end
    end

    // Next-state logic with revolution and error events.
    always_comb begin
        state_nxt = state_q;
        good_nxt  = good_q;
        rev_inc   = 1'b0;
        err_evt   = 1'b0;
        case (state_q)
            IDLE: begin
                if (wrap) begin
                    state_nxt = TRACK;
                    good_nxt  = '0;
                end
            end
            TRACK: begin
                if (match) begin
                    if (wrap) begin
                        rev_inc  = 1'b1;
                        good_nxt = good_q + GR_W'(1);
                        if (good_nxt == GR_W'(LOCK_REVS)) state_nxt = LOCKED;
                    end
                end else begin
                    state_nxt = FAULT;
                    err_evt   = 1'b1;
                end
            end
            LOCKED: begin
                if (match) begin
                    rev_inc = wrap;
                end else begin
                    state_nxt = FAULT;
                    err_evt   = 1'b1;
                end
            end
            default: begin
                if (wrap) begin
                    state_nxt = TRACK;
                    good_nxt  = '0;
                end
            end
        endcase
    end

    // State, sample history and phase decode registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            good_q   <= '0;
            prev_q   <= '0;
            idx_q    <= '0;
            vld_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            good_q   <= good_nxt;
            prev_q   <= bus.phase_in;
            vld_q    <= onehot;
            locked_q <= (state_nxt == LOCKED);
            if (onehot) idx_q <= idx_comb;
        end
    end

    // Sticky fault and revolution counter; a new error beats a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_q <= 1'b0;
            rev_q   <= '0;
        end else begin
            if (err_evt)        fault_q <= 1'b1;
            else if (bus.clear) fault_q <= 1'b0;
            if (bus.clear)      rev_q   <= '0;
            else if (rev_inc)   rev_q   <= rev_q + CNT_W'(1);
        end
    end

`ifdef RING_MON_ERRCNT_EN
    logic [CNT_W-1:0] err_q;

    // Saturating error counter, one count per fault episode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= '0;
        end else if (bus.clear) begin
            err_q <= err_evt ? CNT_W'(1) : '0;
        end else if (err_evt && (err_q != {CNT_W{1'b1}})) begin
            err_q <= err_q + CNT_W'(1);
        end
    end

    assign bus.err_count = err_q;
`else
    assign bus.err_count = '0;
`endif

    assign bus.state     = state_q;
    assign bus.locked    = locked_q;
    assign bus.fault     = fault_q;
    assign bus.phase_idx = idx_q;
    assign bus.phase_vld = vld_q;
    assign bus.rev_count = rev_q;
endmodule

// File: tb/tb_ring_phase_monitor.sv
// Directed bench for ring_phase_monitor: a table of single-cycle vectors plus
// hand-written sequences for the long and asynchronous corner cases.
module tb_ring_phase_monitor;
    logic clk;
    logic reset;

    ring_phase_monitor_if #(.WIDTH(4), .CNT_W(8)) bus ();

    ring_phase_monitor #(.WIDTH(4), .CNT_W(8), .LOCK_REVS(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef RING_MON_ERRCNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        logic [3:0] ph;
        logic       clr;
        logic [1:0] st;
        logic [1:0] idx;
        logic       vld;
        logic       flt;
        logic [7:0] rev;
        logic [7:0] err;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(logic [3:0] ph, logic clr, logic [1:0] st, logic [1:0] idx,
                                logic vld, logic flt, logic [7:0] rev, logic [7:0] err);
        vec_t v;
        v.ph = ph; v.clr = clr; v.st = st; v.idx = idx;
        v.vld = vld; v.flt = flt; v.rev = rev; v.err = err;
        return v;
    endfunction

    task automatic apply(input logic [3:0] ph, input logic clr);
        bus.phase_in = ph;
        bus.clear    = clr;
        @(posedge clk);
        #1;
    endtask

    // err is the value expected with the error counter built in.
    task automatic check(input string name, input logic [1:0] st, input logic [1:0] idx,
                         input logic vld, input logic flt, input logic [7:0] rev,
                         input logic [7:0] err);
        logic [7:0] err_exp;
        err_exp = ERR_EN ? err : 8'd0;
        n_vec++;
        if (bus.state !== st) begin
            n_bad++; $display("FAIL %s state got %0d want %0d", name, bus.state, st);
        end
        if (bus.locked !== (st == 2'b10)) begin
            n_bad++; $display("FAIL %s locked got %0b want %0b", name, bus.locked, (st == 2'b10));
        end
        if (bus.phase_idx !== idx) begin
            n_bad++; $display("FAIL %s phase_idx got %0d want %0d", name, bus.phase_idx, idx);
        end
        if (bus.phase_vld !== vld) begin
            n_bad++; $display("FAIL %s phase_vld got %0b want %0b", name, bus.phase_vld, vld);
        end
        if (bus.fault !== flt) begin
            n_bad++; $display("FAIL %s fault got %0b want %0b", name, bus.fault, flt);
        end
        if (bus.rev_count !== rev) begin
            n_bad++; $display("FAIL %s rev_count got %0d want %0d", name, bus.rev_count, rev);
        end
        if (bus.err_count !== err_exp) begin
            n_bad++; $display("FAIL %s err_count got %0d want %0d", name, bus.err_count, err_exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.phase_in = 4'b0000;
        bus.clear = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        // idle behaviour, acquisition, two revolutions to lock
        vecs.push_back(mk(4'b0010, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(4'b0000, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(4'b0001, 0, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(4'b0010, 0, 1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(4'b0100, 0, 1, 2, 1, 0, 0, 0));
        vecs.push_back(mk(4'b1000, 0, 1, 3, 1, 0, 0, 0));
        vecs.push_back(mk(4'b0001, 0, 1, 0, 1, 0, 1, 0));
        vecs.push_back(mk(4'b0010, 0, 1, 1, 1, 0, 1, 0));
        vecs.push_back(mk(4'b0100, 0, 1, 2, 1, 0, 1, 0));
        vecs.push_back(mk(4'b1000, 0, 1, 3, 1, 0, 1, 0));
        vecs.push_back(mk(4'b0001, 0, 2, 0, 1, 0, 2, 0));
        vecs.push_back(mk(4'b0010, 0, 2, 1, 1, 0, 2, 0));
        vecs.push_back(mk(4'b0100, 0, 2, 2, 1, 0, 2, 0));
        // shift-out from LOCKED, held zeros, non-wrap one-hot stays in FAULT
        vecs.push_back(mk(4'b0000, 0, 3, 2, 0, 1, 2, 1));
        vecs.push_back(mk(4'b0000, 0, 3, 2, 0, 1, 2, 1));
        vecs.push_back(mk(4'b0100, 0, 3, 2, 1, 1, 2, 1));
        // resync keeps fault sticky, clear drops fault and counts
        vecs.push_back(mk(4'b0001, 0, 1, 0, 1, 1, 2, 1));
        vecs.push_back(mk(4'b0010, 1, 1, 1, 1, 0, 0, 0));
        // skipped phase, then multi-hot holds phase_idx
        vecs.push_back(mk(4'b1000, 0, 3, 3, 1, 1, 0, 1));
        vecs.push_back(mk(4'b0011, 0, 3, 3, 0, 1, 0, 1));
        // stalled phase is an error
        vecs.push_back(mk(4'b0001, 0, 1, 0, 1, 1, 0, 1));
        vecs.push_back(mk(4'b0010, 0, 1, 1, 1, 1, 0, 1));
        vecs.push_back(mk(4'b0010, 0, 3, 1, 1, 1, 0, 2));
        vecs.push_back(mk(4'b0001, 0, 1, 0, 1, 1, 0, 2));
        vecs.push_back(mk(4'b0010, 1, 1, 1, 1, 0, 0, 0));
        // clear together with a mismatch: error wins
        vecs.push_back(mk(4'b0110, 1, 3, 1, 0, 1, 0, 1));
        vecs.push_back(mk(4'b0001, 0, 1, 0, 1, 1, 0, 1));
        vecs.push_back(mk(4'b0010, 0, 1, 1, 1, 1, 0, 1));
        vecs.push_back(mk(4'b0100, 0, 1, 2, 1, 1, 0, 1));
        vecs.push_back(mk(4'b1000, 0, 1, 3, 1, 1, 0, 1));
        // clear with wrap: revolution still counts toward lock, rev_count reads 0
        vecs.push_back(mk(4'b0001, 1, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(4'b0010, 0, 1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(4'b0100, 0, 1, 2, 1, 0, 0, 0));
        vecs.push_back(mk(4'b1000, 0, 1, 3, 1, 0, 0, 0));
        vecs.push_back(mk(4'b0001, 0, 2, 0, 1, 0, 1, 0));

        do_reset();
        #1;
        check("reset", 0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            apply(vecs[i].ph, vecs[i].clr);
            check($sformatf("vec%0d", i), vecs[i].st, vecs[i].idx, vecs[i].vld,
                  vecs[i].flt, vecs[i].rev, vecs[i].err);
        end

        // held shift-out for 10 cycles: one error per episode
        for (int k = 0; k < 10; k++) begin
            apply(4'b0000, 0);
            check($sformatf("hold0_%0d", k), 3, 0, 0, 1, 1, 1);
        end

        // back to LOCKED, then asynchronous reset between edges
        apply(4'b0001, 0);
        for (int r = 0; r < 2; r++) begin
            apply(4'b0010, 0);
            apply(4'b0100, 0);
            apply(4'b1000, 0);
            apply(4'b0001, 0);
        end
        check("relock", 2, 0, 1, 1, 3, 1);
        apply(4'b0010, 0);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        // error counter saturation over 257 fault episodes
        for (int k = 1; k <= 257; k++) begin
            apply(4'b0001, 0);
            apply(4'b0000, 0);
            if (k == 1 || k == 254 || k == 255 || k == 257)
                check($sformatf("errsat_%0d", k), 3, 0, 0, 1, 0, (k > 255) ? 8'd255 : 8'(k));
        end

        // revolution counter wraps after 256 revolutions
        do_reset();
        apply(4'b0001, 0);
        for (int r = 1; r <= 256; r++) begin
            apply(4'b0010, 0);
            apply(4'b0100, 0);
            apply(4'b1000, 0);
            apply(4'b0001, 0);
            if (r == 1 || r == 255 || r == 256)
                check($sformatf("revwrap_%0d", r), (r == 1) ? 2'd1 : 2'd2, 0, 1, 0, 8'(r), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
